qadd_rr_sched: RTL and testbench

- Round-robin scheduler that time-shares one sign-magnitude Q16.15 adder among NREQ requesters.
- Each requester offers an operand pair with a valid/ready handshake.
- The scheduler grants one requester, registers its operands and computes the sum.
- It then returns a tagged, registered result on a single response channel with backpressure.
- Sits between the fixed-point processing lanes and the shared adder resource.

---
 rtl/qadd_pkg.sv | 16 +
 rtl/qadd_sm_core.sv | 50 +++++
 rtl/qadd_rr_sched.sv | 123 ++++++++++++
 tb/tb_qadd_rr_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qadd_pkg.sv
// Shared constants and types for the round-robin scheduled sign-magnitude adder.
// Word layout: bit N-1 is the sign, bits N-2:0 are the magnitude (Q16.15 by default).
package qadd_pkg;
    localparam int N        = 32;
    localparam int Q        = 15;
    localparam int SIGN_BIT = N - 1;
    localparam logic [N-2:0] MAG_MAX = '1;

    typedef logic [N-1:0] sm_word_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;
endpackage

// File: rtl/qadd_sm_core.sv
// Combinational sign-magnitude adder; never produces -0 except on a wrapped negative overflow.
// Build option: define QADD_RR_SCHED_SAT_EN to saturate the magnitude on overflow instead of wrapping.
module qadd_sm_core
    import qadd_pkg::*;
(
    input  sm_word_t a,
    input  sm_word_t b,
    output sm_word_t sum,
    output logic     ovf
);
    logic         sa;
    logic         sb;
    logic [N-2:0] ma;
    logic [N-2:0] mb;
    logic [N-1:0] mag_sum;
    logic [N-2:0] mag;
    logic         sign;

    assign sa = a[SIGN_BIT];
    assign sb = b[SIGN_BIT];
    assign ma = a[N-2:0];
    assign mb = b[N-2:0];

    always_comb begin
        mag_sum = {1'b0, ma} + {1'b0, mb};
        ovf     = 1'b0;
        sign    = sa;
        mag     = ma;
        if (sa == sb) begin
            sign = sa;
            ovf  = mag_sum[N-1];
`ifdef QADD_RR_SCHED_SAT_EN
            mag  = mag_sum[N-1] ? MAG_MAX : mag_sum[N-2:0];
`else
            mag  = mag_sum[N-2:0];
`endif
        end else if (ma > mb) begin
            sign = sa;
            mag  = ma - mb;
        end else begin
            sign = sb;
            mag  = mb - ma;
        end
        // A zero magnitude without overflow is always reported as +0.
        if (mag == '0 && !ovf) begin
            sign = 1'b0;
        end
        sum = {sign, mag};
    end
endmodule

// File: rtl/qadd_rr_sched.sv
// Round-robin scheduler sharing one sign-magnitude adder among NREQ requesters,
// with a registered, tagged response channel that honours backpressure.
module qadd_rr_sched
    import qadd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output sm_word_t          rsp_data,
    output logic              rsp_ovf
);
    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] last;
    logic [IDW-1:0] grant;
    logic           grant_found;
    sm_word_t       sel_a;
    sm_word_t       sel_b;
    sm_word_t       a_reg;
    sm_word_t       b_reg;
    logic [IDW-1:0] id_reg;
    sm_word_t       sum;
    logic           sum_ovf;

    // Search starts one past the last granted requester and wraps modulo NREQ.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_sel;
        idx         = 0;
        idx_sel     = '0;
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx     = (int'(last) + k) % NREQ;
            idx_sel = IDW'(idx);
            if (!grant_found && req_valid[idx_sel]) begin
                grant       = idx_sel;
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_a = req_a[i*N +: N];
                sel_b = req_b[i*N +: N];
            end
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        unique case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant] = 1'b1;
                    state_next       = EXEC;
                end
            end
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= IDW'(NREQ - 1);
            a_reg     <= '0;
            b_reg     <= '0;
            id_reg    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_ovf   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        a_reg  <= sel_a;
                        b_reg  <= sel_b;
                        id_reg <= grant;
                        last   <= grant;
                    end
                end
                EXEC: begin
                    rsp_data  <= sum;
                    rsp_ovf   <= sum_ovf;
                    rsp_id    <= id_reg;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    qadd_sm_core u_core (
        .a   (a_reg),
        .b   (b_reg),
        .sum (sum),
        .ovf (sum_ovf)
    );
endmodule

// File: tb/tb_qadd_rr_sched.sv
// Bench for qadd_rr_sched: transaction-level reference model checked every cycle,
// directed literal cases, then randomized requests with random response backpressure.
module tb_qadd_rr_sched;
    localparam int     NREQ   = 4;
    localparam int     IDW    = 2;
    localparam int     W      = 32;
    localparam longint MAGMAX = 64'h7FFF_FFFF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_ovf;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    logic [NREQ-1:0] acc_n = '0;
    int seq = 0;

    int          m_phase = 0;
    int          m_last  = NREQ - 1;
    bit          m_valid = 1'b0;
    int          m_id    = 0;
    logic [31:0] m_data  = '0;
    bit          m_ovf   = 1'b0;

    qadd_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_timeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got no grant within bound, expected a grant", name);
    endtask

    // Value-level reference: operands as signed integers, sum, then re-encode.
    function automatic logic [32:0] model_add(input logic [31:0] a, input logic [31:0] b);
        longint va, vb, s, mag_abs, mag;
        logic   neg, ovf;
        va = longint'(a[30:0]);
        if (a[31]) va = -va;
        vb = longint'(b[30:0]);
        if (b[31]) vb = -vb;
        s       = va + vb;
        neg     = (s < 0);
        mag_abs = neg ? -s : s;
        ovf     = (mag_abs > MAGMAX);
        if (!ovf) mag = mag_abs;
`ifdef QADD_RR_SCHED_SAT_EN
        else mag = MAGMAX;
`else
        else mag = mag_abs - (MAGMAX + 1);
`endif
        if (mag_abs == 0) neg = 1'b0;
        return {ovf, neg, mag[30:0]};
    endfunction

    function automatic bit bit_of(input logic [NREQ-1:0] v, input int i);
        logic [NREQ-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (bit_of(v, (last + k) % NREQ)) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 6))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0000;
            4:       return {1'($urandom_range(0, 1)), 31'h7FFF_FF00 + 31'($urandom_range(0, 255))};
            default: return $urandom;
        endcase
    endfunction

    // Compare against the model, then advance the model to what the next edge must do.
    always @(negedge clk) begin : monitor
        int              g;
        logic [NREQ-1:0] exp_ready;
        logic [32:0]     r;
        acc_n     = req_valid & req_ready;
        g         = (m_phase == 0) ? rr_pick(m_last, req_valid) : -1;
        exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
        if (chk_en) begin
            check_output("req_ready", 32'(req_ready), 32'(exp_ready));
            check_output("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            if (m_valid) begin
                check_output("rsp_id", 32'(rsp_id), 32'(m_id));
                check_output("rsp_data", rsp_data, m_data);
                check_output("rsp_ovf", 32'(rsp_ovf), 32'(m_ovf));
            end
        end
        if (rst) begin
            m_phase = 0;
            m_last  = NREQ - 1;
            m_valid = 1'b0;
        end else begin
            case (m_phase)
                0: if (g >= 0) begin
                    m_last  = g;
                    m_id    = g;
                    r       = model_add(req_a[g*W +: W], req_b[g*W +: W]);
                    m_data  = r[31:0];
                    m_ovf   = r[32];
                    m_phase = 1;
                end
                1: begin
                    m_valid = 1'b1;
                    m_phase = 2;
                end
                default: if (rsp_ready) begin
                    m_valid = 1'b0;
                    m_phase = 0;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc_n;
    endtask

    task automatic load(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a     = (req_a & ~({{(NREQ*W-W){1'b0}}, 32'hFFFF_FFFF} << (i*W))) | ((NREQ*W)'(a) << (i*W));
        req_b     = (req_b & ~({{(NREQ*W-W){1'b0}}, 32'hFFFF_FFFF} << (i*W))) | ((NREQ*W)'(b) << (i*W));
        req_valid = req_valid | (NREQ'(1) << i);
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        int guard;
        rsp_ready = 1'b1;
        guard = 0;
        while ((req_valid != '0 || rsp_valid) && guard < 100) begin
            tick();
            guard++;
        end
        repeat (4) tick();
    endtask

    task automatic apply_stimulus(input int i, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] exp_d, input bit exp_o, input string name);
        bit got;
        got = 1'b0;
        load(i, a, b);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bit_of(req_ready, i)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            report_timeout(name);
            req_valid = '0;
            return;
        end
        tick();
        @(negedge clk);
        check_output({name, "_lat1"}, 32'(rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        check_output({name, "_valid"}, 32'(rsp_valid), 32'd1);
        check_output({name, "_id"}, 32'(rsp_id), 32'(i));
        check_output({name, "_data"}, rsp_data, exp_d);
        check_output({name, "_ovf"}, 32'(rsp_ovf), 32'(exp_o));
        tick();
    endtask

    initial begin
        int gnt[6];
        int exp_order[6];
        int n;
        int guard;
        bit got;
        exp_order = '{0, 1, 2, 3, 0, 1};
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        reset_dut();
        chk_en = 1'b1;

        @(negedge clk);
        check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("reset_rsp_id", 32'(rsp_id), 32'd0);
        check_output("reset_rsp_data", rsp_data, 32'd0);
        check_output("reset_rsp_ovf", 32'(rsp_ovf), 32'd0);
        check_output("reset_req_ready", 32'(req_ready), 32'd0);
        tick();

        apply_stimulus(0, 32'h0000_C000, 32'h0001_2000, 32'h0001_E000, 1'b0, "pos_sum");
        apply_stimulus(1, 32'h0000_8000, 32'h8001_8000, 32'h8001_0000, 1'b0, "mixed");
        apply_stimulus(2, 32'h0000_8000, 32'h8000_8000, 32'h0000_0000, 1'b0, "cancel");
`ifdef QADD_RR_SCHED_SAT_EN
        apply_stimulus(3, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, "ovf_pos");
        apply_stimulus(0, 32'hC000_0000, 32'hC000_0000, 32'hFFFF_FFFF, 1'b1, "ovf_neg");
`else
        apply_stimulus(3, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, "ovf_pos");
        apply_stimulus(0, 32'hC000_0000, 32'hC000_0000, 32'h8000_0000, 1'b1, "ovf_neg");
`endif
        apply_stimulus(1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, "neg_zero");

        // Round robin with every requester continuously valid.
        reset_dut();
        for (int i = 0; i < NREQ; i++) load(i, 32'h1000 * (i + 1), 32'h100 * (i + 1));
        n = 0;
        guard = 0;
        while (n < 6 && guard < 80) begin
            @(negedge clk);
            for (int j = 0; j < NREQ; j++) begin
                if (bit_of(req_ready, j) && n < 6) begin
                    gnt[n] = j;
                    n++;
                end
            end
            tick();
            if (n < 6) begin
                for (int j = 0; j < NREQ; j++) begin
                    if (!bit_of(req_valid, j)) begin
                        seq++;
                        load(j, 32'h1000 * (j + 1) + seq, 32'(seq) << 4);
                    end
                end
            end
            guard++;
        end
        if (n < 6) report_timeout("rr_order");
        for (int k = 0; k < n; k++) check_output("rr_order", 32'(gnt[k]), 32'(exp_order[k]));
        drain();

        // Backpressure held for five cycles with another request pending.
        reset_dut();
        rsp_ready = 1'b0;
        load(2, 32'h0001_0000, 32'h0000_8000);
        load(3, 32'h8000_4000, 32'h0000_2000);
        @(negedge clk);
        check_output("bp_first_grant", 32'(req_ready), 32'h4);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_output("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check_output("bp_hold_id", 32'(rsp_id), 32'd2);
            check_output("bp_hold_data", rsp_data, 32'h0001_8000);
            check_output("bp_hold_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check_output("bp_next_grant", 32'(req_ready), 32'h8);
        tick();
        drain();

        // Reset while a transaction is in EXEC.
        reset_dut();
        load(1, 32'h0000_4000, 32'h0000_4000);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bit_of(req_ready, 1)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) report_timeout("rst_first_grant");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output("rst_no_stale", 32'(rsp_valid), 32'd0);
            tick();
        end
        load(0, 32'h0000_1000, 32'h0000_2000);
        load(2, 32'h0000_3000, 32'h0000_4000);
        @(negedge clk);
        check_output("rst_ptr", 32'(req_ready), 32'h1);
        tick();
        drain();

        // Randomized traffic with random response backpressure.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++) begin
                if (!bit_of(req_valid, i) && $urandom_range(0, 3) == 0) load(i, rand_word(), rand_word());
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
